cnt_frame_sequencer: RTL and testbench

- Sequences one APES count frame end to end: clear the counters, count, then write the N_WORDS count words into the count FIFO through a word-select mux. After that it opens the rocket read window and waits for the FIFO to drain.
- Replaces the single-shot collect/readout FSM with a repeating scheduler that adds FIFO back-pressure, a drain watchdog, a frame counter and sticky error flags.
- Sits between the counter bank, the count FIFO write port and the count parallel shifter enable.

---
 rtl/rocket_pkg.sv | 25 ++
 rtl/drain_watchdog.sv | 34 +++
 rtl/cnt_frame_sequencer.sv | 175 +++++++++++++++++
 tb/tb_cnt_frame_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocket_pkg.sv
// Shared definitions for the rocket count path: sequencer state encoding and
// default frame/timeout constants.
package rocket_pkg;

   localparam int unsigned N_WORDS_DEF = 53;
   localparam int unsigned TIMEOUT_DEF = 50_000_000;   // 1 s at 50 MHz
   localparam int unsigned WORD_SEL_W  = 6;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      COUNT = 3'd2,
      LOAD  = 3'd3,
      DRAIN = 3'd4
   } seq_state_t;

   // Bits needed to hold values 0..max_val (at least 1).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = 1;
      while ((64'(1) << w) <= 64'(max_val)) w++;
      return w;
   endfunction

endpackage

// File: rtl/drain_watchdog.sv
// Loadable cycle counter that saturates and flags expiry after LIMIT enabled cycles.
module drain_watchdog
   import rocket_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_DEF
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          load,
   input  logic [cnt_width(LIMIT)-1:0]   load_val,
   input  logic                          en,
   output logic [cnt_width(LIMIT)-1:0]   count,
   output logic                          expired_c
);

   localparam int unsigned CW = cnt_width(LIMIT);

   // Expiry is reached in the LIMIT-th enabled cycle counted from zero.
   assign expired_c = (count == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !expired_c) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/cnt_frame_sequencer.sv
// Repeating APES count-frame scheduler: clear, count, load N_WORDS words into
// the count FIFO with back-pressure, then hold the read window until drained.
module cnt_frame_sequencer
   import rocket_pkg::*;
#(
   parameter int unsigned N_WORDS        = N_WORDS_DEF,
   parameter int unsigned CLR_CYCLES     = 4,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter int unsigned EMPTY_GUARD    = 2,
   parameter int unsigned CNT_W          = 16
)(
   input  logic                  clk50,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  collect_done,
   input  logic                  err_clr,
   input  logic                  fifo_full,
   input  logic                  fifo_empty,
   output logic                  cnt_clr,
   output logic                  cnt_start,
   output logic [WORD_SEL_W-1:0] word_sel,
   output logic                  fifo_we,
   output logic                  fifo_flush,
   output logic                  rd_window,
   output logic                  frame_done,
   output logic [CNT_W-1:0]      frame_cnt,
   output logic                  timeout_err,
   output logic                  overrun
);

   localparam int unsigned CLR_W = cnt_width(CLR_CYCLES);
   localparam int unsigned WD_W  = cnt_width(TIMEOUT_CYCLES);
   localparam logic [WORD_SEL_W-1:0] LAST_WORD = WORD_SEL_W'(N_WORDS - 1);

   seq_state_t             state;
   seq_state_t             state_nxt;
   logic [CLR_W-1:0]       clr_cnt;
   logic [CLR_W-1:0]       clr_cnt_nxt;
   logic [WORD_SEL_W-1:0]  word_sel_nxt;
   logic                   fifo_we_nxt;
   logic                   flush_nxt;
   logic                   done_nxt;
   logic [CNT_W-1:0]       frame_cnt_nxt;
   logic                   timeout_set;
   logic                   overrun_set;
   logic                   timeout_nxt;
   logic                   overrun_nxt;
   logic                   was_count;
   logic                   wr_acc;
   logic                   empty_ok;
   logic [WD_W-1:0]        wd_count;
   logic                   wd_expired_c;

   drain_watchdog #(
      .LIMIT     (TIMEOUT_CYCLES)
   ) u_drain_watchdog (
      .clk       (clk50),
      .rst       (rst),
      .clr       (state != DRAIN),
      .load      (1'b0),
      .load_val  ('0),
      .en        (state == DRAIN),
      .count     (wd_count),
      .expired_c (wd_expired_c)
   );

   // A write only counts when the FIFO was not full in the cycle it was offered.
   assign wr_acc   = fifo_we & ~fifo_full;
   assign empty_ok = fifo_empty && (32'(wd_count) >= EMPTY_GUARD);

   always_ff @(posedge clk50) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      clr_cnt_nxt   = '0;
      word_sel_nxt  = word_sel;
      fifo_we_nxt   = 1'b0;
      flush_nxt     = 1'b0;
      done_nxt      = 1'b0;
      frame_cnt_nxt = frame_cnt;
      timeout_set   = 1'b0;
      // collect_done lingering one cycle past the COUNT->LOAD edge is benign.
      overrun_set   = collect_done && (state != COUNT) && !((state == LOAD) && was_count);

      case (state)
         IDLE: begin
            word_sel_nxt = '0;
            if (enable) state_nxt = CLEAR;
         end
         CLEAR: begin
            if (!enable) begin
               state_nxt = IDLE;
            end else if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
               state_nxt = COUNT;
            end else begin
               clr_cnt_nxt = clr_cnt + CLR_W'(1);
            end
         end
         COUNT: begin
            if (collect_done) begin
               state_nxt    = LOAD;
               word_sel_nxt = '0;
               fifo_we_nxt  = !fifo_full;
            end else if (!enable) begin
               state_nxt = IDLE;
            end
         end
         LOAD: begin
            if (wr_acc && (word_sel == LAST_WORD)) begin
               state_nxt    = DRAIN;
               word_sel_nxt = '0;
            end else begin
               word_sel_nxt = word_sel + WORD_SEL_W'(wr_acc);
               fifo_we_nxt  = !fifo_full;
            end
         end
         DRAIN: begin
            if (empty_ok) begin
               done_nxt      = 1'b1;
               frame_cnt_nxt = frame_cnt + CNT_W'(1);
               state_nxt     = enable ? CLEAR : IDLE;
            end else if (wd_expired_c) begin
               timeout_set = 1'b1;
               flush_nxt   = 1'b1;
               state_nxt   = enable ? CLEAR : IDLE;
            end
         end
         default: begin
            state_nxt    = IDLE;
            word_sel_nxt = '0;
         end
      endcase

      timeout_nxt = timeout_set | (timeout_err & ~err_clr);
      overrun_nxt = overrun_set | (overrun & ~err_clr);
   end

   // Control outputs follow the next state so they line up with the state register.
   always_ff @(posedge clk50) begin
      if (rst) begin
         clr_cnt     <= '0;
         was_count   <= 1'b0;
         cnt_clr     <= 1'b0;
         cnt_start   <= 1'b0;
         word_sel    <= '0;
         fifo_we     <= 1'b0;
         fifo_flush  <= 1'b0;
         rd_window   <= 1'b0;
         frame_done  <= 1'b0;
         frame_cnt   <= '0;
         timeout_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         clr_cnt     <= clr_cnt_nxt;
         was_count   <= (state == COUNT);
         cnt_clr     <= (state_nxt == CLEAR);
         cnt_start   <= (state_nxt == COUNT);
         word_sel    <= word_sel_nxt;
         fifo_we     <= fifo_we_nxt;
         fifo_flush  <= flush_nxt;
         rd_window   <= (state_nxt == DRAIN);
         frame_done  <= done_nxt;
         frame_cnt   <= frame_cnt_nxt;
         timeout_err <= timeout_nxt;
         overrun     <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_cnt_frame_sequencer.sv
// Directed bench for cnt_frame_sequencer: nominal frame, back-pressure, guard,
// overrun, timeout, enable drops, counter wrap and mid-frame reset.
module tb_cnt_frame_sequencer;

   logic       clk50;
   logic       rst;
   logic       enable;
   logic       collect_done;
   logic       err_clr;
   logic       fifo_full;
   logic       fifo_empty;
   logic       cnt_clr;
   logic       cnt_start;
   logic [5:0] word_sel;
   logic       fifo_we;
   logic       fifo_flush;
   logic       rd_window;
   logic       frame_done;
   logic [1:0] frame_cnt;
   logic       timeout_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;
   int flush_count = 0;
   int done_count = 0;
   int excl_viol = 0;
   logic [5:0] wr_log[$];

   cnt_frame_sequencer #(
      .N_WORDS        (53),
      .CLR_CYCLES     (4),
      .TIMEOUT_CYCLES (100),
      .EMPTY_GUARD    (2),
      .CNT_W          (2)
   ) dut (
      .clk50        (clk50),
      .rst          (rst),
      .enable       (enable),
      .collect_done (collect_done),
      .err_clr      (err_clr),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .cnt_clr      (cnt_clr),
      .cnt_start    (cnt_start),
      .word_sel     (word_sel),
      .fifo_we      (fifo_we),
      .fifo_flush   (fifo_flush),
      .rd_window    (rd_window),
      .frame_done   (frame_done),
      .frame_cnt    (frame_cnt),
      .timeout_err  (timeout_err),
      .overrun      (overrun)
   );

   initial clk50 = 1'b0;
   always #10 clk50 = ~clk50;

   // Mid-cycle observer: logs accepted writes and counts pulses.
   always @(negedge clk50) begin
      if (fifo_we === 1'b1 && fifo_full === 1'b0) wr_log.push_back(word_sel);
      if (fifo_flush === 1'b1) flush_count++;
      if (frame_done === 1'b1) done_count++;
      if ($countones({cnt_clr, cnt_start, fifo_we, rd_window}) > 1) excl_viol++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_cnt_start(input string tag);
      int n = 0;
      while (!cnt_start && n < 50) begin
         tick();
         n++;
      end
      check(tag, 32'(cnt_start), 32'd1);
   endtask

   // Wait for COUNT, count 3 cycles, then pulse collect_done; returns in LOAD cycle 0.
   task automatic start_frame(input string tag);
      wait_cnt_start(tag);
      ticks(3);
      collect_done = 1'b1;
      tick();
      collect_done = 1'b0;
   endtask

   task automatic wait_rd(input string tag, input int start_n, input int exp_n);
      int n = start_n;
      while (!rd_window && n < 300) begin
         tick();
         n++;
      end
      check(tag, 32'(n), 32'(exp_n));
   endtask

   task automatic wait_done(input string tag, input int exp_n);
      int n = 0;
      while (!frame_done && n < 50) begin
         tick();
         n++;
      end
      check(tag, 32'(n), 32'(exp_n));
   endtask

   task automatic check_writes(input string tag, input int base);
      int bad = 0;
      int got;
      got = wr_log.size() - base;
      check({tag, "_count"}, 32'(got), 32'd53);
      for (int i = 0; i < got && i < 53; i++) begin
         if (wr_log[base + i] !== 6'(i)) bad++;
      end
      check({tag, "_order"}, 32'(bad), 32'd0);
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({cnt_clr, cnt_start, fifo_we, fifo_flush, rd_window, frame_done,
                  timeout_err, overrun, word_sel, frame_cnt});
   endfunction

   initial begin
      int base;
      int sb;
      int n;

      rst = 1'b1;
      enable = 1'b0;
      collect_done = 1'b0;
      err_clr = 1'b0;
      fifo_full = 1'b0;
      fifo_empty = 1'b0;
      ticks(3);
      check("reset_outputs", all_outs(), 32'd0);
      rst = 1'b0;
      tick();
      check("idle_outputs", all_outs(), 32'd0);

      // Frame 1: nominal, collect_done held one extra cycle into LOAD
      enable = 1'b1;
      tick();
      check("clr_rise", 32'(cnt_clr), 32'd1);
      n = 0;
      while (cnt_clr && n < 20) begin
         n++;
         tick();
      end
      check("clr_len", 32'(n), 32'd4);
      check("count_start", 32'(cnt_start), 32'd1);
      ticks(19);
      base = wr_log.size();
      collect_done = 1'b1;
      tick();
      check("load_entry_sel", 32'(word_sel), 32'd0);
      check("load_entry_we", 32'(fifo_we), 32'd1);
      check("load_entry_start", 32'(cnt_start), 32'd0);
      tick();
      collect_done = 1'b0;
      wait_rd("f1_load_len", 1, 53);
      check_writes("f1_writes", base);
      ticks(30);
      fifo_empty = 1'b1;
      tick();
      check("f1_done", 32'(frame_done), 32'd1);
      check("f1_frame_cnt", 32'(frame_cnt), 32'd1);
      check("f1_rd_drop", 32'(rd_window), 32'd0);
      check("f1_next_clear", 32'(cnt_clr), 32'd1);
      check("f1_no_overrun", 32'(overrun), 32'd0);
      fifo_empty = 1'b0;
      tick();
      check("f1_done_pulse", 32'(frame_done), 32'd0);

      // Frame 2: back-pressure on words 10..14, overrun in LOAD, empty on DRAIN entry
      start_frame("f2_start");
      base = wr_log.size();
      ticks(10);
      check("stall_sel", 32'(word_sel), 32'd10);
      check("stall_we_before", 32'(fifo_we), 32'd1);
      fifo_full = 1'b1;
      sb = wr_log.size();
      ticks(5);
      fifo_full = 1'b0;
      check("stall_no_writes", 32'(wr_log.size()), 32'(sb));
      check("stall_sel_hold", 32'(word_sel), 32'd10);
      check("stall_we_low", 32'(fifo_we), 32'd0);
      tick();
      collect_done = 1'b1;
      tick();
      collect_done = 1'b0;
      check("overrun_set", 32'(overrun), 32'd1);
      wait_rd("f2_load_len", 0, 42);
      check_writes("f2_writes", base);
      fifo_empty = 1'b1;
      wait_done("guard_delay", 3);
      check("f2_frame_cnt", 32'(frame_cnt), 32'd2);
      fifo_empty = 1'b0;

      // Frame 3: drain never empties -> watchdog
      start_frame("f3_start");
      wait_rd("f3_load_len", 0, 53);
      n = 0;
      while (!fifo_flush && n < 300) begin
         tick();
         n++;
      end
      check("timeout_len", 32'(n), 32'd100);
      check("timeout_err_set", 32'(timeout_err), 32'd1);
      check("timeout_no_done", 32'(frame_done), 32'd0);
      check("timeout_frame_cnt", 32'(frame_cnt), 32'd2);
      check("timeout_rd_drop", 32'(rd_window), 32'd0);
      tick();
      check("flush_pulse", 32'(fifo_flush), 32'd0);
      check("timeout_sticky", 32'(timeout_err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("err_clr_timeout", 32'(timeout_err), 32'd0);
      check("err_clr_overrun", 32'(overrun), 32'd0);

      // Frame 4: enable drop while counting
      wait_cnt_start("f4_start");
      ticks(2);
      enable = 1'b0;
      sb = wr_log.size();
      tick();
      check("count_abort", 32'({cnt_clr, cnt_start, fifo_we, rd_window}), 32'd0);
      ticks(3);
      check("count_abort_idle", 32'({cnt_clr, cnt_start, fifo_we, rd_window}), 32'd0);
      check("count_abort_nowr", 32'(wr_log.size()), 32'(sb));

      // Frame 5: enable drop mid-LOAD still completes the frame
      enable = 1'b1;
      start_frame("f5_start");
      base = wr_log.size();
      ticks(20);
      enable = 1'b0;
      wait_rd("f5_load_len", 20, 53);
      check_writes("f5_writes", base);
      ticks(5);
      fifo_empty = 1'b1;
      wait_done("f5_done", 1);
      check("f5_frame_cnt", 32'(frame_cnt), 32'd3);
      check("f5_to_idle", 32'(cnt_clr), 32'd0);
      fifo_empty = 1'b0;
      ticks(3);
      check("f5_idle_stay", 32'({cnt_clr, cnt_start, fifo_we, rd_window}), 32'd0);

      // Frame 6: frame counter wraps
      enable = 1'b1;
      start_frame("f6_start");
      wait_rd("f6_load_len", 0, 53);
      fifo_empty = 1'b1;
      wait_done("f6_done", 3);
      check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
      fifo_empty = 1'b0;

      // Frame 7: reset in the middle of LOAD
      start_frame("f7_start");
      ticks(2);
      collect_done = 1'b1;
      tick();
      collect_done = 1'b0;
      check("f7_overrun", 32'(overrun), 32'd1);
      ticks(2);
      rst = 1'b1;
      tick();
      check("midload_reset", all_outs(), 32'd0);
      rst = 1'b0;
      enable = 1'b0;
      ticks(2);
      check("reset_idle", all_outs(), 32'd0);

      check("flush_total", 32'(flush_count), 32'd1);
      check("done_total", 32'(done_count), 32'd4);
      check("mutual_exclusion", 32'(excl_viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
